// File: rtl/ctrl_pkg.sv
// Shared types and instruction field constants for the ctrl_seq
// fetch/execute sequencer and its decoder.
package ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam int SRC_LO  = 6;
    localparam int DEST_LO = 4;
    localparam int COND_LO = 2;
    localparam int OP_LO   = 0;

    localparam logic [1:0] SRC_IMM  = 2'd0;
    localparam logic [1:0] SRC_ADD  = 2'd1;
    localparam logic [1:0] SRC_SUB  = 2'd2;
    localparam logic [1:0] SRC_RSVD = 2'd3;

    localparam logic [1:0] DEST_A   = 2'd0;
    localparam logic [1:0] DEST_B   = 2'd1;
    localparam logic [1:0] DEST_OUT = 2'd2;
    localparam logic [1:0] DEST_PC  = 2'd3;

    localparam logic [1:0] COND_ALWAYS = 2'd0;
    localparam logic [1:0] COND_ZERO   = 2'd1;
    localparam logic [1:0] COND_CARRY  = 2'd2;
    localparam logic [1:0] COND_NCARRY = 2'd3;

    localparam logic [1:0] OP_HALT = 2'b11;

    function automatic logic [1:0] field(input logic [7:0] ir, input int lo);
        return ir[lo +: 2];
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: condition evaluation plus all
// bus-enable and load strobes for the current sequencer state.
import ctrl_pkg::*;

module ctrl_decode #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] ir,
    input  state_t            state,
    input  logic              aIsZero,
    input  logic              flagCarry,
    output logic              take,
    output logic              romBarE,
    output logic              assertBarE,
    output logic              doSubtract,
    output logic              loadA,
    output logic              loadB,
    output logic              loadOut,
    output logic              pc_sel,
    output logic              pc_inc
);

    logic [1:0] src;
    logic [1:0] dest;
    logic [1:0] cond;
    logic [1:0] op;
    logic       exec;
    logic       act;

    assign src  = field(ir[7:0], SRC_LO);
    assign dest = field(ir[7:0], DEST_LO);
    assign cond = field(ir[7:0], COND_LO);
    assign op   = field(ir[7:0], OP_LO);
    assign exec = (state == EXEC) && (op != OP_HALT);

    always_comb begin
        take = 1'b0;
        unique case (cond)
            COND_ALWAYS: take = 1'b1;
            COND_ZERO:   take = aIsZero;
            COND_CARRY:  take = flagCarry;
            COND_NCARRY: take = !flagCarry;
            default:     take = 1'b0;
        endcase
    end

    // Immediates always consume their byte, even when not taken.
    always_comb begin
        romBarE    = 1'b1;
        assertBarE = 1'b1;
        doSubtract = 1'b0;
        pc_inc     = 1'b0;
        act        = 1'b0;
        if (exec) begin
            unique case (src)
                SRC_IMM: begin
                    pc_inc  = 1'b1;
                    romBarE = !take;
                    act     = take;
                end
                SRC_ADD, SRC_SUB: begin
                    assertBarE = !take;
                    doSubtract = take && (src == SRC_SUB);
                    act        = take;
                end
                default: act = 1'b0;
            endcase
        end
    end

    assign loadA   = act && (dest == DEST_A);
    assign loadB   = act && (dest == DEST_B);
    assign loadOut = act && (dest == DEST_OUT);
    assign pc_sel  = exec && (src != SRC_RSVD) && (dest == DEST_PC);

endmodule

// File: rtl/ctrl_seq.sv
// Fetch/execute control sequencer: owns pc, ir and the FSM state.
// Optional CTRL_SEQ_SINGLE_STEP_EN adds a 'step' input gating FETCH.
import ctrl_pkg::*;

module ctrl_seq #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [DATA_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic [DATA_W-1:0] dbus,
    input  logic              aIsZero,
    input  logic              flagCarry,
    output logic              romBarE,
    output logic              assertBarE,
    output logic              doSubtract,
    output logic              loadA,
    output logic              loadB,
    output logic              loadOut,
    output logic              halted
);

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_nx;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] ir_nx;
    logic              take;
    logic              pc_sel;
    logic              pc_inc;
    logic              advance;

`ifdef CTRL_SEQ_SINGLE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    ctrl_decode #(.DATA_W(DATA_W)) u_decode (
        .ir         (ir),
        .state      (state),
        .aIsZero    (aIsZero),
        .flagCarry  (flagCarry),
        .take       (take),
        .romBarE    (romBarE),
        .assertBarE (assertBarE),
        .doSubtract (doSubtract),
        .loadA      (loadA),
        .loadB      (loadB),
        .loadOut    (loadOut),
        .pc_sel     (pc_sel),
        .pc_inc     (pc_inc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            ir    <= ir_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        unique case (state)
            FETCH: begin
                if (advance) begin
                    ir_nx    = rom_data;
                    pc_nx    = pc + 1'b1;
                    state_nx = (field(rom_data[7:0], OP_LO) == OP_HALT)
                             ? HALT : EXEC;
                end
            end
            EXEC: begin
                state_nx = FETCH;
                // A taken PC load wins over the immediate increment.
                if (pc_sel && take)
                    pc_nx = dbus;
                else if (pc_inc)
                    pc_nx = pc + 1'b1;
            end
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    assign rom_addr = pc;
    assign halted   = (state == HALT);

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed scenarios plus random
// programs checked against an instruction-level reference model.
module tb_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] dbus;
    logic       aIsZero = 1'b0;
    logic       flagCarry = 1'b0;
    logic       romBarE, assertBarE, doSubtract;
    logic       loadA, loadB, loadOut, halted;
`ifdef CTRL_SEQ_SINGLE_STEP_EN
    logic       step = 1'b1;
`endif

    logic [7:0] rom [256];
    logic [7:0] alu_val = 8'h00;
    logic [7:0] idle_val = 8'h00;

    int n_assert = 0;
    int n_fail = 0;
    int fz = -1;
    int fc = -1;
    int m_pc = 0;
    bit m_halted = 1'b0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];
    assign dbus = !romBarE ? rom_data : (!assertBarE ? alu_val : idle_val);

    ctrl_seq #(.DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef CTRL_SEQ_SINGLE_STEP_EN
        .step       (step),
`endif
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .dbus       (dbus),
        .aIsZero    (aIsZero),
        .flagCarry  (flagCarry),
        .romBarE    (romBarE),
        .assertBarE (assertBarE),
        .doSubtract (doSubtract),
        .loadA      (loadA),
        .loadB      (loadB),
        .loadOut    (loadOut),
        .halted     (halted)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        aIsZero   = (fz >= 0) ? fz[0] : 1'($urandom_range(0, 1));
        flagCarry = (fc >= 0) ? fc[0] : 1'($urandom_range(0, 1));
        alu_val   = 8'($urandom);
        idle_val  = 8'($urandom);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_romBarE"}, {7'd0, romBarE}, 8'd1);
        chk({tag, "_assertBarE"}, {7'd0, assertBarE}, 8'd1);
        chk({tag, "_loads"}, {5'd0, loadA, loadB, loadOut}, 8'd0);
        chk({tag, "_doSub"}, {7'd0, doSubtract}, 8'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_pc = 0;
        m_halted = 1'b0;
    endtask

    // Fetch cycle of the next instruction, then its execute cycle.
    // Entered and left just after a falling edge.
    task automatic run_instr();
        logic [7:0] ins;
        int src, dest, cond, nxt;
        bit take, act;
        logic [7:0] bus;
        drive_inputs();
        #1;
        chk("fetch_addr", rom_addr, 8'(m_pc));
        chk("fetch_halted", {7'd0, halted}, 8'd0);
        chk_quiet("fetch");
        ins = rom[m_pc];
        m_pc = (m_pc + 1) % 256;
        @(negedge clk);
        if (ins[1:0] == 2'b11) begin
            m_halted = 1'b1;
            return;
        end
        src  = int'(ins) / 64;
        dest = (int'(ins) / 16) % 4;
        cond = (int'(ins) / 4) % 4;
        drive_inputs();
        #1;
        case (cond)
            0: take = 1'b1;
            1: take = aIsZero;
            2: take = flagCarry;
            default: take = !flagCarry;
        endcase
        act = take && (src != 3);
        chk("exec_addr", rom_addr, 8'(m_pc));
        chk("exec_halted", {7'd0, halted}, 8'd0);
        chk("exec_romBarE", {7'd0, romBarE}, {7'd0, !(src == 0 && take)});
        chk("exec_assertBarE", {7'd0, assertBarE},
            {7'd0, !(act && src != 0)});
        chk("exec_doSub", {7'd0, doSubtract}, {7'd0, act && src == 2});
        chk("exec_loads", {5'd0, loadA, loadB, loadOut},
            {5'd0, act && dest == 0, act && dest == 1, act && dest == 2});
        bus = (src == 0) ? rom[m_pc] : alu_val;
        nxt = (src == 0) ? (m_pc + 1) % 256 : m_pc;
        if (act && dest == 3) nxt = int'(bus);
        m_pc = nxt;
        @(negedge clk);
    endtask

    task automatic chk_halted(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive_inputs();
            #1;
            chk("halt_flag", {7'd0, halted}, 8'd1);
            chk("halt_addr", rom_addr, 8'(m_pc));
            chk_quiet("halt");
            @(negedge clk);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    initial begin
        clear_rom();
        @(negedge clk);

        // IMM -> A, then the following fetch
        rom[1] = 8'h05;
        do_reset();
        run_instr();
        run_instr();

        // ALU sub -> B, always
        clear_rom();
        rom[0] = 8'h90;
        do_reset();
        run_instr();
        run_instr();

        // IMM -> PC if aIsZero, taken then not taken
        clear_rom();
        rom[0] = 8'h34;
        rom[1] = 8'h40;
        fz = 1;
        do_reset();
        run_instr();
        chk("jump_taken", 8'(m_pc), 8'h40);
        run_instr();
        fz = 0;
        do_reset();
        run_instr();
        chk("jump_not_taken", 8'(m_pc), 8'h02);
        run_instr();
        fz = -1;

        // pc wrap at 8'hFF
        clear_rom();
        rom[0] = 8'h30;
        rom[1] = 8'hFF;
        rom[8'hFF] = 8'h00;
        do_reset();
        run_instr();
        run_instr();
        chk("wrap_pc", 8'(m_pc), 8'h01);
        run_instr();

        // HALT, frozen, then reset recovers
        clear_rom();
        rom[0] = 8'h03;
        do_reset();
        run_instr();
        chk_halted(20);
        do_reset();
        run_instr();

        // reset applied mid-EXEC while loadA is high
        clear_rom();
        do_reset();
        drive_inputs();
        #1;
        chk("pre_fetch_addr", rom_addr, 8'h00);
        @(negedge clk);
        drive_inputs();
        #1;
        chk("mid_exec_loadA", {7'd0, loadA}, 8'd1);
        do_reset();
        drive_inputs();
        #1;
        chk("post_rst_loadA", {7'd0, loadA}, 8'd0);
        chk("post_rst_addr", rom_addr, 8'h00);
        chk_quiet("post_rst");
        run_instr();

        // random programs, rarely halting
        for (int p = 0; p < 30; p++) begin
            for (int i = 0; i < 256; i++) begin
                rom[i] = 8'($urandom);
                if (rom[i][1:0] == 2'b11 && $urandom_range(0, 9) != 0)
                    rom[i][1:0] = 2'b00;
            end
            do_reset();
            for (int k = 0; k < 40 && !m_halted; k++) run_instr();
            if (m_halted) chk_halted(3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
